// File: rtl/adc_spi_if.sv
// Serial ADC link between the polling host (master) and the ADC responder (slave).
interface adc_spi_if;
    logic ad_clk;
    logic cs_n;
    logic din;
    logic dout;
    logic dout_oe;

    modport master (output ad_clk, output cs_n, output din, input dout, input dout_oe);
    modport slave  (input ad_clk, input cs_n, input din, output dout, output dout_oe);
endinterface

// File: rtl/adc_spi_responder.sv
// MCP3008-style ADC responder: decodes start/SGL/D2..D0 from the host and shifts a
// null bit plus the DATA_W-bit result out MSB first, all on the oversampling clk.
module adc_spi_responder #(
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    adc_spi_if.slave                 spi,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [2:0]               sel_ch,
    output logic                     sgl,
    output logic                     conv_strobe,
    output logic                     frame_done,
    output logic                     frame_abort
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, WAIT_START, CMD, NULLB, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] ak_sync, cs_sync, din_sync;
    logic                   ak_q;
    logic                   ak_s, cs_act, din_s, rise, fall;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [2:0]        cmd_q, cmd_n;
    logic [DATA_W-1:0] sr_q, sr_n;
    logic              dout_q, dout_n, oe_q, oe_n;
    logic [2:0]        sel_n;
    logic              sgl_n, strobe_n, done_n, abort_n;

    logic [DATA_W-1:0] ch [NUM_CH];
    logic [2:0]        idx;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] result;

    // Synchronizers for the host-domain inputs; cs_n idles deasserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ak_sync  <= '0;
            cs_sync  <= '1;
            din_sync <= '0;
            ak_q     <= 1'b0;
        end else begin
            ak_sync  <= (ak_sync << 1)  | SYNC_STAGES'(spi.ad_clk);
            cs_sync  <= (cs_sync << 1)  | SYNC_STAGES'(spi.cs_n);
            din_sync <= (din_sync << 1) | SYNC_STAGES'(spi.din);
            ak_q     <= ak_sync[SYNC_STAGES-1];
        end
    end

    assign ak_s   = ak_sync[SYNC_STAGES-1];
    assign cs_act = ~cs_sync[SYNC_STAGES-1];
    assign din_s  = din_sync[SYNC_STAGES-1];
    assign rise   = ak_s & ~ak_q & cs_act;
    assign fall   = ~ak_s & ak_q & cs_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            sr_q        <= '0;
            dout_q      <= 1'b0;
            oe_q        <= 1'b0;
            sel_ch      <= '0;
            sgl         <= 1'b0;
            conv_strobe <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            cmd_q       <= cmd_n;
            sr_q        <= sr_n;
            dout_q      <= dout_n;
            oe_q        <= oe_n;
            sel_ch      <= sel_n;
            sgl         <= sgl_n;
            conv_strobe <= strobe_n;
            frame_done  <= done_n;
            frame_abort <= abort_n;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(NUM_CH); k++) ch[k] = ch_data[k*DATA_W +: DATA_W];
    end

    // Result for the command completed by the current din sample (valid on the D0 edge)
    always_comb begin
        idx    = {cmd_q[1:0], din_s};
        diff   = {1'b0, ch[idx]} - {1'b0, ch[idx ^ 3'd1]};
        result = cmd_q[2] ? ch[idx] : (diff[DATA_W] ? '0 : diff[DATA_W-1:0]);
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        cmd_n    = cmd_q;
        sr_n     = sr_q;
        dout_n   = dout_q;
        oe_n     = oe_q;
        sel_n    = sel_ch;
        sgl_n    = sgl;
        strobe_n = 1'b0;
        done_n   = 1'b0;
        abort_n  = 1'b0;
        if (!cs_act && (state_q == CMD || state_q == NULLB || state_q == DATA)) begin
            abort_n = 1'b1;
            dout_n  = 1'b0;
            oe_n    = 1'b0;
            state_n = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (cs_act) state_n = WAIT_START;
                WAIT_START: begin
                    if (!cs_act) state_n = IDLE;
                    else if (rise && din_s) begin
                        state_n = CMD;
                        cnt_n   = '0;
                    end
                end
                CMD: if (rise) begin
                    if (cnt_q == CNT_W'(3)) begin
                        sel_n    = idx;
                        sgl_n    = cmd_q[2];
                        sr_n     = result;
                        strobe_n = 1'b1;
                        cnt_n    = '0;
                        state_n  = NULLB;
                    end else begin
                        cmd_n = {cmd_q[1:0], din_s};
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                NULLB: if (fall) begin
                    dout_n  = 1'b0;
                    oe_n    = 1'b1;
                    state_n = DATA;
                end
                DATA: if (fall) begin
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        dout_n  = 1'b0;
                        oe_n    = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        dout_n = sr_q[DATA_W-1];
                        sr_n   = sr_q << 1;
                        cnt_n  = cnt_q + CNT_W'(1);
                    end
                end
                DONE: if (!cs_act) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign spi.dout    = dout_q;
    assign spi.dout_oe = oe_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized host driving the ADC responder; a monitor scores every strobe, read bit and end pulse.
module tb_adc_spi_responder;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SYNC   = 2;

    typedef struct {
        logic [2:0]        sel;
        logic              sgl;
        logic [DATA_W-1:0] res;
        int                abort_k;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [2:0] sel_ch;
    logic sgl, conv_strobe, frame_done, frame_abort;

    adc_spi_if spi ();

    adc_spi_responder #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .spi(spi), .ch_data(ch_data), .sel_ch(sel_ch), .sgl(sgl),
        .conv_strobe(conv_strobe), .frame_done(frame_done), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    bit   tog_en;
    int   tick_n, cap_tick;
    logic [NUM_CH*DATA_W-1:0] cap_val;

    bit   active;
    int   bits;
    exp_t cur;
    logic prev_ak;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] rand_ch();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[NUM_CH*DATA_W-1:0];
    endfunction

    // Reference: plain integer arithmetic on the selected channel pair
    function automatic logic [DATA_W-1:0] model(input logic [NUM_CH*DATA_W-1:0] chv,
                                                 input logic s, input logic [2:0] d);
        int a, b;
        a = int'(chv[int'(d)*DATA_W +: DATA_W]);
        b = int'(chv[int'(d ^ 3'd1)*DATA_W +: DATA_W]);
        if (s) return DATA_W'(a);
        return (a > b) ? DATA_W'(a - b) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
        tick_n++;
        if (tog_en) ch_data = (tick_n == cap_tick) ? cap_val : rand_ch();
    endtask

    task automatic wait_t(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input bit b, input int hp, input bit is_d0);
        spi.ad_clk = 1'b0;
        spi.din    = b;
        wait_t(hp);
        if (is_d0) cap_tick = tick_n + int'(SYNC);
        spi.ad_clk = 1'b1;
        wait_t(hp);
    endtask

    task automatic frame(input int lead, input bit s, input logic [2:0] d, input int hp,
                         input int abort_k, input int rst_k);
        exp_t e;
        int   n_rise;
        spi.cs_n = 1'b0; spi.ad_clk = 1'b0; spi.din = 1'b0;
        wait_t(hp + 2);
        repeat (lead) send_bit(1'b0, hp, 1'b0);
        send_bit(1'b1, hp, 1'b0);
        send_bit(s, hp, 1'b0);
        send_bit(d[2], hp, 1'b0);
        send_bit(d[1], hp, 1'b0);
        e.sel = d; e.sgl = s; e.abort_k = abort_k;
        e.res = model(tog_en ? cap_val : ch_data, s, d);
        exp_q.push_back(e);
        send_bit(d[0], hp, 1'b1);
        n_rise = (abort_k >= 0) ? abort_k + 1 : (rst_k >= 0) ? rst_k + 1 : int'(DATA_W) + 1;
        for (int i = 0; i < n_rise; i++) begin
            spi.ad_clk = 1'b0; wait_t(hp);
            spi.ad_clk = 1'b1; wait_t(hp);
        end
        if (abort_k >= 0) begin
            spi.cs_n = 1'b1;
            wait_t(int'(SYNC) + 1);
            chk("abort_oe_low", 32'(spi.dout_oe), 0);
            chk("abort_dout_low", 32'(spi.dout), 0);
        end else if (rst_k >= 0) begin
            rst = 1'b1;
            #1;
            chk("rst_dout", 32'(spi.dout), 0);
            chk("rst_oe", 32'(spi.dout_oe), 0);
            chk("rst_sel", 32'(sel_ch), 0);
            chk("rst_sgl", 32'(sgl), 0);
            spi.cs_n = 1'b1; spi.ad_clk = 1'b0;
            wait_t(3);
            rst = 1'b0;
        end else begin
            spi.ad_clk = 1'b0;
            wait_t(hp);
        end
        spi.cs_n = 1'b1; spi.ad_clk = 1'b0;
        wait_t(hp + 4);
    endtask

    // Monitor: host-side view of every strobe, every bit read on a rising ad_clk, and frame end
    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0;
        end else begin
            if (conv_strobe) begin
                chk("strobe_while_open", 32'(active), 0);
                chk("strobe_has_expect", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("sel_ch", 32'(sel_ch), 32'(cur.sel));
                    chk("sgl", 32'(sgl), 32'(cur.sgl));
                    active = 1'b1;
                    bits   = 0;
                end
            end
            if (spi.ad_clk && !prev_ak && !spi.cs_n && active) begin
                chk("read_oe", 32'(spi.dout_oe), 1);
                chk("read_in_range", 32'(bits <= int'(DATA_W)), 1);
                if (bits == 0) chk("null_bit", 32'(spi.dout), 0);
                else if (bits <= int'(DATA_W)) chk("data_bit", 32'(spi.dout), 32'(cur.res[int'(DATA_W) - bits]));
                bits++;
            end
            if (frame_done) begin
                chk("done_in_frame", 32'(active), 1);
                chk("done_not_abort_frame", 32'(cur.abort_k < 0), 1);
                chk("done_bits_read", 32'(bits), 32'(DATA_W + 1));
                chk("done_oe_low", 32'(spi.dout_oe), 0);
                active = 1'b0;
            end
            if (frame_abort) begin
                chk("abort_in_frame", 32'(active), 1);
                chk("abort_expected", 32'(cur.abort_k >= 0), 1);
                chk("abort_bits_read", 32'(bits), 32'(cur.abort_k + 1));
                active = 1'b0;
            end
        end
        prev_ak = spi.ad_clk;
    end

    initial begin
        logic [DATA_W-1:0] v;
        rst = 1'b1; spi.cs_n = 1'b1; spi.ad_clk = 1'b0; spi.din = 1'b0;
        ch_data = '0; tog_en = 1'b0; tick_n = 0; cap_tick = -1; cap_val = '0;
        active = 1'b0; bits = 0; prev_ak = 1'b0;
        wait_t(3);
        chk("reset_dout", 32'(spi.dout), 0);
        chk("reset_oe", 32'(spi.dout_oe), 0);
        chk("reset_sel", 32'(sel_ch), 0);
        chk("reset_sgl", 32'(sgl), 0);
        chk("reset_pulses", 32'({conv_strobe, frame_done, frame_abort}), 0);
        rst = 1'b0;
        wait_t(3);

        // Single-ended ch5 = 2A5
        ch_data = rand_ch(); v = 10'h2A5; ch_data[5*DATA_W +: DATA_W] = v;
        frame(0, 1'b1, 3'd5, 4, -1, -1);
        // Pseudo-differential, saturating and positive
        ch_data = rand_ch(); v = 10'd300; ch_data[2*DATA_W +: DATA_W] = v;
        v = 10'd500; ch_data[3*DATA_W +: DATA_W] = v;
        frame(0, 1'b0, 3'd2, 4, -1, -1);
        frame(0, 1'b0, 3'd3, 4, -1, -1);
        // Leading zeros before the start bit
        ch_data = rand_ch(); v = 10'h3FF; ch_data[0 +: DATA_W] = v;
        frame(5, 1'b1, 3'd0, 3, -1, -1);
        // Abort after the 4th data bit, then a clean frame
        frame(0, 1'b1, 3'd0, 4, 4, -1);
        ch_data = rand_ch(); v = 10'h001; ch_data[7*DATA_W +: DATA_W] = v;
        frame(1, 1'b1, 3'd7, 4, -1, -1);
        // Reset mid-readout, then a clean frame
        ch_data = rand_ch();
        frame(0, 1'b1, 3'd6, 4, -1, 5);
        frame(0, 1'b0, 3'd1, 5, -1, -1);
        // Minimum ad_clk phase with ch_data churning except in the capture cycle
        tog_en = 1'b1;
        cap_val = rand_ch(); frame(0, 1'b1, 3'($urandom_range(0, 7)), 3, -1, -1);
        cap_val = rand_ch(); frame(2, 1'b0, 3'($urandom_range(0, 7)), 3, -1, -1);
        tog_en = 1'b0; cap_tick = -1;
        // Random frames
        for (int n = 0; n < 20; n++) begin
            ch_data = rand_ch();
            frame(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  int'($urandom_range(3, 6)), -1, -1);
        end

        wait_t(10);
        chk("expect_queue_drained", 32'(exp_q.size()), 0);
        chk("no_open_frame", 32'(active), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
